dw_ram_2p_be_dff: RTL and testbench

DW_RAM_2P_BE_DFF -- requirements
Module: dw_ram_2p_be_dff

---
 rtl/dw_ram_2p_be_dff.sv | 126 ++++++++++++
 tb/tb_dw_ram_2p_be_dff.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dw_ram_2p_be_dff.sv
// Two-port flip-flop RAM with active-low byte enables, optional registered read with
// write-to-read forwarding, and a sequential whole-array clear engine driven by init_n.
module dw_ram_2p_be_dff #(
    parameter int unsigned data_width = 8,
    parameter int unsigned depth      = 8,
    parameter int unsigned addr_width = 3,
    parameter int unsigned rst_mode   = 0,
    parameter int unsigned rd_mode    = 1,
    parameter int unsigned bypass     = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cs_n,
    input  logic                              wr_n,
    input  logic [addr_width-1:0]             wr_addr,
    input  logic [addr_width-1:0]             rd_addr,
    input  logic [data_width-1:0]             data_in,
    input  logic [((data_width+7)/8)-1:0]     be_n,
    input  logic                              init_n,
    output logic [data_width-1:0]             data_out,
    output logic                              init_busy
);

    localparam logic [addr_width:0]   DepthW   = (addr_width + 1)'(depth);
    localparam logic [addr_width-1:0] LastAddr = addr_width'(depth - 1);

    typedef enum logic {StIdle, StClear} state_e;

    state_e                r_state;
    logic [addr_width-1:0] r_cnt;
    logic                  r_busy;
    logic [data_width-1:0] r_mem [depth];

    logic                  w_wr_valid;
    logic                  w_rd_valid;
    logic                  w_wr_en;
    logic [data_width-1:0] w_old;
    logic [data_width-1:0] w_wr_word;
    logic [data_width-1:0] w_rd_word;

    assign w_wr_valid = ({1'b0, wr_addr} < DepthW);
    assign w_rd_valid = ({1'b0, rd_addr} < DepthW);
    assign w_wr_en    = !cs_n && !wr_n && !r_busy && w_wr_valid;
    assign w_old      = w_wr_valid ? r_mem[wr_addr] : '0;
    assign w_rd_word  = w_rd_valid ? r_mem[rd_addr] : '0;
    assign init_busy  = r_busy;

    // Merged word: new bytes in enabled lanes, stored bytes elsewhere.
    always_comb begin
        w_wr_word = '0;
        for (int unsigned b = 0; b < data_width; b++) begin
            w_wr_word[b] = be_n[b / 8] ? w_old[b] : data_in[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!init_n) begin
                        r_state <= StClear;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                StClear: begin
                    if (r_cnt == LastAddr) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    if (rst_mode == 0) begin : g_mem_rst
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < depth; i++) begin
                    r_mem[i] <= '0;
                end
            end else if (r_busy) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wr_en) begin
                r_mem[wr_addr] <= w_wr_word;
            end
        end
    end else begin : g_mem_keep
        // Array survives reset; writes are simply suppressed while reset is held.
        always_ff @(posedge clk) begin
            if (rst_n) begin
                if (r_busy) begin
                    r_mem[r_cnt] <= '0;
                end else if (w_wr_en) begin
                    r_mem[wr_addr] <= w_wr_word;
                end
            end
        end
    end

    if (rd_mode == 0) begin : g_rd_comb
        assign data_out = w_rd_word;
    end else begin : g_rd_reg
        logic [data_width-1:0] r_dout;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_dout <= '0;
            end else if (!cs_n) begin
                if ((bypass != 0) && w_wr_en && (wr_addr == rd_addr)) begin
                    r_dout <= w_wr_word;
                end else begin
                    r_dout <= w_rd_word;
                end
            end
        end
        assign data_out = r_dout;
    end

endmodule

// File: tb/tb_dw_ram_2p_be_dff.sv
// Scoreboard bench: two DUT configurations (8-bit defaults; 16-bit, depth 6, keep-on-reset,
// no forwarding). Reads push expected data; a monitor pops one cycle after each read edge.
module tb_dw_ram_2p_be_dff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instance A: defaults
    logic       a_rst_n, a_cs_n, a_wr_n, a_init_n, a_be_n, a_busy;
    logic [2:0] a_wa, a_ra;
    logic [7:0] a_din, a_dout;

    // Instance B: 16-bit, depth 6, rst_mode 1, bypass 0
    logic        b_rst_n, b_cs_n, b_wr_n, b_init_n, b_busy;
    logic [1:0]  b_be_n;
    logic [2:0]  b_wa, b_ra;
    logic [15:0] b_din, b_dout;

    dw_ram_2p_be_dff u_a (
        .clk(clk), .rst_n(a_rst_n), .cs_n(a_cs_n), .wr_n(a_wr_n),
        .wr_addr(a_wa), .rd_addr(a_ra), .data_in(a_din), .be_n(a_be_n),
        .init_n(a_init_n), .data_out(a_dout), .init_busy(a_busy)
    );

    dw_ram_2p_be_dff #(
        .data_width(16), .depth(6), .addr_width(3), .rst_mode(1), .rd_mode(1), .bypass(0)
    ) u_b (
        .clk(clk), .rst_n(b_rst_n), .cs_n(b_cs_n), .wr_n(b_wr_n),
        .wr_addr(b_wa), .rd_addr(b_ra), .data_in(b_din), .be_n(b_be_n),
        .init_n(b_init_n), .data_out(b_dout), .init_busy(b_busy)
    );

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic        a_rd = 1'b0, b_rd = 1'b0;
    logic        a_vld, b_vld;

    always @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) a_vld <= 1'b0;
        else          a_vld <= a_rd;
    end

    always @(posedge clk or negedge b_rst_n) begin
        if (!b_rst_n) b_vld <= 1'b0;
        else          b_vld <= b_rd;
    end

    always @(negedge clk) begin
        if (a_vld) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_rd: got %h expected nothing queued", a_dout);
            end else begin
                chk("a_rd", {8'h00, a_dout}, q_a.pop_front());
            end
        end
        if (b_vld) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_rd: got %h expected nothing queued", b_dout);
            end else begin
                chk("b_rd", b_dout, q_b.pop_front());
            end
        end
    end

    task automatic a_cyc(input logic cs_n, input logic wr_n, input logic [2:0] wa,
                         input logic [7:0] din, input logic be, input logic [2:0] ra,
                         input logic rd, input logic [7:0] exp, input logic ini);
        a_cs_n = cs_n; a_wr_n = wr_n; a_wa = wa; a_din = din; a_be_n = be;
        a_ra = ra; a_init_n = ini; a_rd = rd;
        if (rd) q_a.push_back({8'h00, exp});
        @(negedge clk);
    endtask

    task automatic a_wr(input logic [2:0] wa, input logic [7:0] din, input logic be);
        a_cyc(1'b0, 1'b0, wa, din, be, wa, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic a_rdc(input logic [2:0] ra, input logic [7:0] exp);
        a_cyc(1'b0, 1'b1, 3'd0, 8'h00, 1'b1, ra, 1'b1, exp, 1'b1);
    endtask

    task automatic a_idle();
        a_cyc(1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic b_cyc(input logic cs_n, input logic wr_n, input logic [2:0] wa,
                         input logic [15:0] din, input logic [1:0] be, input logic [2:0] ra,
                         input logic rd, input logic [15:0] exp, input logic ini);
        b_cs_n = cs_n; b_wr_n = wr_n; b_wa = wa; b_din = din; b_be_n = be;
        b_ra = ra; b_init_n = ini; b_rd = rd;
        if (rd) q_b.push_back(exp);
        @(negedge clk);
    endtask

    task automatic b_wr(input logic [2:0] wa, input logic [15:0] din, input logic [1:0] be);
        b_cyc(1'b0, 1'b0, wa, din, be, wa, 1'b0, 16'h0000, 1'b1);
    endtask

    task automatic b_rdc(input logic [2:0] ra, input logic [15:0] exp);
        b_cyc(1'b0, 1'b1, 3'd0, 16'h0000, 2'b11, ra, 1'b1, exp, 1'b1);
    endtask

    task automatic b_idle();
        b_cyc(1'b1, 1'b1, 3'd0, 16'h0000, 2'b11, 3'd0, 1'b0, 16'h0000, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_rst_n = 1'b0; a_cs_n = 1'b1; a_wr_n = 1'b1; a_wa = '0; a_ra = '0;
        a_din = '0; a_be_n = 1'b1; a_init_n = 1'b1;
        b_rst_n = 1'b0; b_cs_n = 1'b1; b_wr_n = 1'b1; b_wa = '0; b_ra = '0;
        b_din = '0; b_be_n = 2'b11; b_init_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("a_rst_dout", {8'h00, a_dout}, 16'h0000);
        chk("a_rst_busy", {15'h0, a_busy}, 16'h0000);
        chk("b_rst_dout", b_dout, 16'h0000);
        chk("b_rst_busy", {15'h0, b_busy}, 16'h0000);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // A: basic write/read, cleared-by-reset word, hold with cs_n high
        a_wr(3'd3, 8'hA5, 1'b0);
        a_rdc(3'd3, 8'hA5);
        a_rdc(3'd0, 8'h00);
        a_cyc(1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 8'h00, 1'b1);
        // A: disabled lane leaves word untouched
        a_wr(3'd4, 8'hFF, 1'b1);
        a_rdc(3'd4, 8'h00);
        // A: collision forwarding, then merge with lane disabled
        a_wr(3'd5, 8'h11, 1'b0);
        a_cyc(1'b0, 1'b0, 3'd5, 8'h22, 1'b0, 3'd5, 1'b1, 8'h22, 1'b1);
        a_rdc(3'd5, 8'h22);
        a_cyc(1'b0, 1'b0, 3'd5, 8'h77, 1'b1, 3'd5, 1'b1, 8'h22, 1'b1);

        // A: fill, then clear sequence
        for (int i = 0; i < 8; i++) a_wr(3'(i), 8'h10 + 8'(i), 1'b0);
        a_rdc(3'd0, 8'h10);
        a_rdc(3'd7, 8'h17);
        a_cyc(1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("a_busy_hi", {15'h0, a_busy}, 16'h0001);
            case (k)
                2:       a_rdc(3'd1, 8'h00);
                3:       a_wr(3'd0, 8'hEE, 1'b0);
                5:       a_rdc(3'd6, 8'h16);
                default: a_idle();
            endcase
        end
        chk("a_busy_lo", {15'h0, a_busy}, 16'h0000);
        for (int i = 0; i < 8; i++) a_rdc(3'(i), 8'h00);
        a_idle();

        // B: byte-enable merge on 16-bit word
        b_wr(3'd2, 16'h1234, 2'b00);
        b_wr(3'd2, 16'hABCD, 2'b10);
        b_rdc(3'd2, 16'h12CD);
        // B: collision without forwarding returns old word
        b_wr(3'd5, 16'h0011, 2'b00);
        b_cyc(1'b0, 1'b0, 3'd5, 16'h0022, 2'b00, 3'd5, 1'b1, 16'h0011, 1'b1);
        b_rdc(3'd5, 16'h0022);
        // B: out-of-range write discarded, out-of-range read is zero
        b_wr(3'd7, 16'hFFFF, 2'b00);
        b_rdc(3'd6, 16'h0000);
        b_rdc(3'd7, 16'h0000);
        b_rdc(3'd2, 16'h12CD);
        b_rdc(3'd5, 16'h0022);

        // B: clear aborted by reset after three words
        for (int i = 0; i < 6; i++) b_wr(3'(i), 16'h0100 + 16'(i), 2'b00);
        b_cyc(1'b1, 1'b1, 3'd0, 16'h0000, 2'b11, 3'd0, 1'b0, 16'h0000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("b_busy_hi", {15'h0, b_busy}, 16'h0001);
            b_idle();
        end
        b_rst_n = 1'b0;
        #1;
        chk("b_abort_busy", {15'h0, b_busy}, 16'h0000);
        chk("b_abort_dout", b_dout, 16'h0000);
        @(negedge clk);
        b_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) b_rdc(3'(i), (i < 3) ? 16'h0000 : 16'h0100 + 16'(i));
        b_idle();
        b_idle();

        chk("a_drain", 16'(q_a.size()), 16'h0000);
        chk("b_drain", 16'(q_b.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
